fetch_decode_buffer: RTL and testbench

Two-entry instruction buffer between the IF stage (PC generator) and the decode stage of the basic processor. It captures each fetched PC/instruction pair from IF and the instruction ROM, and presents them to decode with a valid/ready handshake. It back-pressures IF with `Stall` when full and flushes on a taken branch. It optionally detects the HALT opcode and drives `Halt` back to IF.

---
 rtl/fetch_decode_buffer.sv | 100 ++++++++++
 tb/tb_fetch_decode_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_buffer.sv
// Two-entry PC/instruction buffer between IF and decode: valid/ready to decode, Stall back-pressure to IF, flush on taken branch.
// Define FDB_HALT_DETECT_EN to build HALT opcode detection and the sticky Halt state.
module fetch_decode_buffer #(
    parameter int         IW      = 9,
    parameter int         AW      = 8,
    parameter logic [3:0] HALT_OP = 4'b1111
) (
    input  logic          CLK,
    input  logic          Init_n,
    input  logic [AW-1:0] PC_in,
    input  logic [IW-1:0] Instr_in,
    input  logic          in_valid,
    input  logic          Flush,
    input  logic          dec_ready,
    output logic [AW-1:0] PC_out,
    output logic [IW-1:0] Instr_out,
    output logic          out_valid,
    output logic          Stall,
    output logic          Halt
);
    // Handshake: decode takes the head on a rising edge with out_valid && dec_ready; IF's word is
    // captured on a rising edge with in_valid && !Stall. Flush on the same edge cancels both.
    logic [AW-1:0] pc_mem_q    [2];
    logic [IW-1:0] instr_mem_q [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          halted;
    logic          enq, deq;

    // Stall and out_valid derive from registered state only, so IF never sees a path from dec_ready.
    assign out_valid = (count_q != 2'd0) && !halted;
    assign Stall     = (count_q == 2'd2) || halted;
    assign PC_out    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
    assign Instr_out = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign Halt      = halted;

    assign enq = in_valid && !Stall && !Flush && !halted;
    assign deq = out_valid && dec_ready && !Flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (enq) wr_ptr_d = ~wr_ptr_q;
            if (deq) rd_ptr_d = ~rd_ptr_q;
            if (enq && !deq)      count_d = count_q + 2'd1;
            else if (!enq && deq) count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (enq) begin
                pc_mem_q[wr_ptr_q]    <= PC_in;
                instr_mem_q[wr_ptr_q] <= Instr_in;
            end
        end
    end

`ifdef FDB_HALT_DETECT_EN
    typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_e;
    state_e state_q, state_d;

    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) state_q <= ST_RUN;
        else         state_q <= state_d;
    end

    // HALTED only leaves through reset; Flush does not touch it.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && deq && Instr_out[IW-1:IW-4] == HALT_OP)
            state_d = ST_HALTED;
    end

    always_comb begin
        halted = (state_q == ST_HALTED);
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Randomized bench for fetch_decode_buffer against a queue-based model of the buffer rules.
// Honors FDB_HALT_DETECT_EN the same way the design does.
module tb_fetch_decode_buffer;
    localparam int         IW      = 9;
    localparam int         AW      = 8;
    localparam logic [3:0] HALT_OP = 4'b1111;

    logic          CLK;
    logic          Init_n;
    logic [AW-1:0] PC_in;
    logic [IW-1:0] Instr_in;
    logic          in_valid;
    logic          Flush;
    logic          dec_ready;
    logic [AW-1:0] PC_out;
    logic [IW-1:0] Instr_out;
    logic          out_valid;
    logic          Stall;
    logic          Halt;

    fetch_decode_buffer #(.IW(IW), .AW(AW), .HALT_OP(HALT_OP)) dut (
        .CLK       (CLK),
        .Init_n    (Init_n),
        .PC_in     (PC_in),
        .Instr_in  (Instr_in),
        .in_valid  (in_valid),
        .Flush     (Flush),
        .dec_ready (dec_ready),
        .PC_out    (PC_out),
        .Instr_out (Instr_out),
        .out_valid (out_valid),
        .Stall     (Stall),
        .Halt      (Halt)
    );

    // Model state: buffered {PC, Instr} entries in order, plus the sticky halt flag.
    logic [AW+IW-1:0] exp_q[$];
    logic             m_halted;
    int               chk_cnt = 0;
    int               err_cnt = 0;

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic             ov;
        logic [AW+IW-1:0] head;
        logic [AW-1:0]    pc;
        logic [IW-1:0]    ins;
        ov   = (exp_q.size() != 0) && !m_halted;
        head = (exp_q.size() != 0) ? exp_q[0] : '0;
        pc   = ov ? head[AW+IW-1:IW] : '0;
        ins  = ov ? head[IW-1:0] : '0;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".pc_out"},    32'(PC_out),    32'(pc));
        check({tag, ".instr_out"}, 32'(Instr_out), 32'(ins));
        check({tag, ".stall"},     32'(Stall),     32'((exp_q.size() == 2) || m_halted));
        check({tag, ".halt"},      32'(Halt),      32'(m_halted));
    endtask

    // Apply one rising edge's worth of buffer rules to the model.
    task automatic model_edge(input logic v, input logic [AW-1:0] pc, input logic [IW-1:0] ins,
                              input logic fl, input logic rdy);
        logic             full, ov, do_enq, do_deq;
        logic [AW+IW-1:0] head;
        full = (exp_q.size() == 2);
        ov   = (exp_q.size() != 0) && !m_halted;
        if (fl) begin
            exp_q.delete();
        end else begin
            do_deq = ov && rdy;
            do_enq = v && !full && !m_halted;
            if (do_deq) begin
                head = exp_q.pop_front();
`ifdef FDB_HALT_DETECT_EN
                if (head[IW-1:IW-4] == HALT_OP) m_halted = 1'b1;
`endif
            end
            if (do_enq) exp_q.push_back({pc, ins});
        end
    endtask

    // Driver: called at a falling edge; returns at the next falling edge.
    task automatic drive_cycle(input string tag, input logic v, input logic [AW-1:0] pc,
                               input logic [IW-1:0] ins, input logic fl, input logic rdy);
        in_valid  = v;
        PC_in     = pc;
        Instr_in  = ins;
        Flush     = fl;
        dec_ready = rdy;
        #1;
        check_outputs(tag);
        @(posedge CLK);
        model_edge(v, pc, ins, fl, rdy);
        @(negedge CLK);
    endtask

    task automatic apply_reset(input int cycles);
        Init_n    = 1'b0;
        in_valid  = 1'b0;
        Flush     = 1'b0;
        dec_ready = 1'b0;
        PC_in     = '0;
        Instr_in  = '0;
        exp_q.delete();
        m_halted  = 1'b0;
        #1;
        check_outputs("reset");
        repeat (cycles) @(posedge CLK);
        @(negedge CLK);
        check_outputs("reset_hold");
        Init_n = 1'b1;
    endtask

    // Drop Init_n between edges and require zeroed outputs before the next rising edge.
    task automatic async_reset_mid();
        #2 Init_n = 1'b0;
        #1;
        check("async.out_valid", 32'(out_valid), 32'd0);
        check("async.pc_out",    32'(PC_out),    32'd0);
        check("async.instr_out", 32'(Instr_out), 32'd0);
        check("async.stall",     32'(Stall),     32'd0);
        check("async.halt",      32'(Halt),      32'd0);
        exp_q.delete();
        m_halted = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        Init_n = 1'b1;
    endtask

    initial begin
        Init_n    = 1'b0;
        in_valid  = 1'b0;
        Flush     = 1'b0;
        dec_ready = 1'b0;
        PC_in     = '0;
        Instr_in  = '0;
        m_halted  = 1'b0;
        @(negedge CLK);
        apply_reset(2);

        // Streaming at full rate
        for (int i = 0; i < 5; i++)
            drive_cycle("stream", 1'b1, AW'(i), IW'(9'h010 + i), 1'b0, 1'b1);
        repeat (2) drive_cycle("stream_drain", 1'b0, '0, '0, 1'b0, 1'b1);

        // Back-pressure: third word must be refused
        drive_cycle("bp", 1'b1, 8'h10, 9'h020, 1'b0, 1'b0);
        drive_cycle("bp", 1'b1, 8'h11, 9'h021, 1'b0, 1'b0);
        drive_cycle("bp", 1'b1, 8'h12, 9'h022, 1'b0, 1'b0);
        repeat (3) drive_cycle("bp_drain", 1'b0, '0, '0, 1'b0, 1'b1);

        // Flush with a full buffer and a simultaneous incoming word
        drive_cycle("flush", 1'b1, 8'h20, 9'h030, 1'b0, 1'b0);
        drive_cycle("flush", 1'b1, 8'h21, 9'h031, 1'b0, 1'b0);
        drive_cycle("flush", 1'b1, 8'h22, 9'h032, 1'b1, 1'b1);
        drive_cycle("flush", 1'b1, 8'h30, 9'h040, 1'b0, 1'b0);
        drive_cycle("flush", 1'b0, '0, '0, 1'b0, 1'b0);
        drive_cycle("flush", 1'b0, '0, '0, 1'b0, 1'b1);

        // HALT opcode
        drive_cycle("halt", 1'b1, 8'h05, 9'h1E0, 1'b0, 1'b0);
        drive_cycle("halt", 1'b1, 8'h06, 9'h016, 1'b0, 1'b0);
        repeat (3) drive_cycle("halt", 1'b1, 8'h07, 9'h017, 1'b0, 1'b1);
        drive_cycle("halt_flush", 1'b0, '0, '0, 1'b1, 1'b1);
        repeat (2) drive_cycle("halt_after", 1'b1, 8'h08, 9'h018, 1'b0, 1'b1);
        apply_reset(2);
        drive_cycle("post_halt", 1'b1, 8'h09, 9'h019, 1'b0, 1'b0);
        drive_cycle("post_halt", 1'b0, '0, '0, 1'b0, 1'b1);

        // Asynchronous reset with two entries held
        drive_cycle("async_fill", 1'b1, 8'h40, 9'h050, 1'b0, 1'b0);
        drive_cycle("async_fill", 1'b1, 8'h41, 9'h051, 1'b0, 1'b0);
        async_reset_mid();
        drive_cycle("post_async", 1'b0, '0, '0, 1'b0, 1'b1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0 || (m_halted && $urandom_range(0, 7) == 0))
                apply_reset(1);
            else if (exp_q.size() == 2 && $urandom_range(0, 99) == 0)
                async_reset_mid();
            else
                drive_cycle("rand", $urandom_range(0, 3) != 0, AW'($urandom), IW'($urandom),
                            $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
